fpu_sequencer: RTL and testbench

FPU_SEQUENCER -- requirements
Module: fpu_sequencer

---
 rtl/fpu_sequencer_pkg.sv | 36 +++
 rtl/fpu_sequencer_if.sv | 28 ++
 rtl/fpu_seq_timer.sv | 21 ++
 rtl/fpu_sequencer.sv | 98 +++++++++
 tb/tb_fpu_sequencer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/fpu_sequencer_pkg.sv
// Shared types for the FPU sequencer: operand formats, FPU op/flag types,
// sequencer state encoding and canonical NaN patterns.
package fpu_sequencer_pkg;

  typedef struct packed { logic sign; logic [4:0]  exp; logic [9:0]  frac; } fp16_t;
  typedef struct packed { logic sign; logic [7:0]  exp; logic [22:0] frac; } fp32_t;
  typedef struct packed { logic sign; logic [10:0] exp; logic [51:0] frac; } fp64_t;

  typedef enum logic [2:0] {
    FPU_ADD, FPU_SUB, FPU_MUL, FPU_DIV, FPU_SQRT, FPU_FMA, FPU_CMP
  } fpuOp_t;

  typedef struct packed { logic nv; logic dz; logic of; logic uf; logic nx; } statusFlag_t;
  typedef logic [3:0] condCode_t;
  typedef struct packed { logic lt; logic eq; logic gt; } fpuComp_t;

  typedef enum logic [1:0] { IDLE, ISSUE, WAIT, RESP } fpSeqState_t;

  localparam int TIMEOUT_DEFAULT = 64;

  localparam logic [15:0] NAN16 = 16'h7E00;
  localparam logic [31:0] NAN32 = 32'h7FC0_0000;
  localparam logic [63:0] NAN64 = 64'h7FF8_0000_0000_0000;

  localparam statusFlag_t FLAG_NV = '{nv: 1'b1, dz: 1'b0, of: 1'b0, uf: 1'b0, nx: 1'b0};

  // Quiet NaN right-justified in 64 bits; callers slice to the format width.
  function automatic logic [63:0] canonNaN(input int width);
    case (width)
      16:      return {48'd0, NAN16};
      32:      return {32'd0, NAN32};
      default: return NAN64;
    endcase
  endfunction

endpackage

// File: rtl/fpu_sequencer_if.sv
// Request/response handshake bundle between a requester and the FPU sequencer.
interface fpu_sequencer_if import fpu_sequencer_pkg::*; #(
  parameter type FP_T = fp16_t
);
  logic        req_valid;
  logic        req_ready;
  fpuOp_t      req_op;
  FP_T         req_a;
  FP_T         req_b;
  FP_T         req_c;
  logic        resp_valid;
  logic        resp_ready;
  FP_T         resp_result;
  condCode_t   resp_cc;
  statusFlag_t resp_flags;
  fpuComp_t    resp_comps;
  logic        resp_timeout;

  modport master (
    output req_valid, req_op, req_a, req_b, req_c, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_cc, resp_flags, resp_comps, resp_timeout
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_c, resp_ready,
    output req_ready, resp_valid, resp_result, resp_cc, resp_flags, resp_comps, resp_timeout
  );
endinterface

// File: rtl/fpu_seq_timer.sv
// Clearable saturating cycle counter; terminal marks the last permitted wait cycle.
module fpu_seq_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic terminal
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n)                             count <= '0;
    else if (clr)                             count <= '0;
    else if (en && count != CW'(TIMEOUT))     count <= count + CW'(1);

  assign terminal = (count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/fpu_sequencer.sv
// Single-outstanding FPU sequencer: latches a request, pulses start, waits for
// done (bounded by TIMEOUT) and holds the response until the requester takes it.
module fpu_sequencer import fpu_sequencer_pkg::*; #(
  parameter type FP_T    = fp16_t,
  parameter int  TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  fpu_sequencer_if.slave host,
  output FP_T         fpuIn1,
  output FP_T         fpuIn2,
  output FP_T         fpuIn3,
  output fpuOp_t      op,
  output logic        start,
  input  FP_T         fpuOut,
  input  logic        fpuDone,
  input  condCode_t   condCodes,
  input  statusFlag_t statusFlags,
  input  fpuComp_t    comps,
  output statusFlag_t sticky_flags,
  input  logic        flags_clear,
  output logic        busy
);
  localparam int          FW    = $bits(FP_T);
  localparam logic [63:0] NAN_W = canonNaN(FW);

  fpSeqState_t state, nextState;
  logic        accept, capture, tmoTerm;
  statusFlag_t capFlags;

  // All handshake outputs are pure decodes of the state register.
  assign host.req_ready  = (state == IDLE);
  assign host.resp_valid = (state == RESP);
  assign start           = (state == ISSUE);
  assign busy            = (state != IDLE);

  assign accept   = host.req_valid && host.req_ready;
  assign capture  = (state == WAIT) && (fpuDone || tmoTerm);
  assign capFlags = fpuDone ? statusFlags : FLAG_NV;

  fpu_seq_timer #(.TIMEOUT(TIMEOUT)) uTimer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr      (state == ISSUE),
    .en       ((state == WAIT) && !fpuDone),
    .terminal (tmoTerm)
  );

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= nextState;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept)          nextState = ISSUE;
      ISSUE:                        nextState = WAIT;
      WAIT:    if (capture)         nextState = RESP;
      RESP:    if (host.resp_ready) nextState = IDLE;
      default:                      nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      fpuIn1 <= '0;
      fpuIn2 <= '0;
      fpuIn3 <= '0;
      op     <= FPU_ADD;
    end else if (accept) begin
      fpuIn1 <= host.req_a;
      fpuIn2 <= host.req_b;
      fpuIn3 <= host.req_c;
      op     <= host.req_op;
    end

  // A timeout reports the canonical NaN with only NV raised.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      host.resp_result  <= '0;
      host.resp_cc      <= '0;
      host.resp_flags   <= '0;
      host.resp_comps   <= '0;
      host.resp_timeout <= 1'b0;
    end else if (capture) begin
      host.resp_result  <= fpuDone ? fpuOut    : FP_T'(NAN_W[FW-1:0]);
      host.resp_cc      <= fpuDone ? condCodes : '0;
      host.resp_flags   <= capFlags;
      host.resp_comps   <= fpuDone ? comps     : '0;
      host.resp_timeout <= !fpuDone;
    end

  // Clear takes effect before the OR, so a coincident capture leaves only new flags.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n)         sticky_flags <= '0;
    else if (capture)     sticky_flags <= statusFlag_t'((flags_clear ? '0 : sticky_flags) | capFlags);
    else if (flags_clear) sticky_flags <= '0;
endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed bench for fpu_sequencer: latency, flags, timeout, backpressure, reset abort.
module tb_fpu_sequencer;
  import fpu_sequencer_pkg::*;

  logic        clock, reset_n;
  fp16_t       fpuIn1, fpuIn2, fpuIn3, fpuOut;
  fpuOp_t      op;
  logic        start, fpuDone, flags_clear, busy;
  condCode_t   condCodes;
  statusFlag_t statusFlags, sticky_flags;
  fpuComp_t    comps;
  int          checks, failures, lat;

  fpu_sequencer_if #(.FP_T(fp16_t)) host();

  fpu_sequencer #(.FP_T(fp16_t), .TIMEOUT(8)) dut (
    .clock(clock), .reset_n(reset_n), .host(host),
    .fpuIn1(fpuIn1), .fpuIn2(fpuIn2), .fpuIn3(fpuIn3), .op(op), .start(start),
    .fpuOut(fpuOut), .fpuDone(fpuDone), .condCodes(condCodes), .statusFlags(statusFlags),
    .comps(comps), .sticky_flags(sticky_flags), .flags_clear(flags_clear), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Accept one request, then wait (bounded) for resp_valid; lat counts edges from accept.
  task automatic runOp(input fpuOp_t o, input logic [15:0] a, b, c, output int l);
    host.req_valid = 1'b1; host.req_op = o;
    host.req_a = fp16_t'(a); host.req_b = fp16_t'(b); host.req_c = fp16_t'(c);
    tick();
    host.req_valid = 1'b0;
    l = 1;
    while (!host.resp_valid && l < 40) begin tick(); l++; end
    if (!host.resp_valid) chk("resp_wait_bound", 64'(host.resp_valid), 64'd1);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0; host.req_valid = 1'b0; host.req_op = FPU_ADD;
    host.req_a = '0; host.req_b = '0; host.req_c = '0; host.resp_ready = 1'b1;
    fpuOut = '0; fpuDone = 1'b1; condCodes = '0; statusFlags = '0; comps = '0;
    flags_clear = 1'b0;
    repeat (2) tick();
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_valid",  64'(host.resp_valid), 64'd0);
    chk("rst_start",  64'(start), 64'd0);
    chk("rst_sticky", 64'(sticky_flags), 64'd0);
    chk("rst_op",     64'(op), 64'(FPU_ADD));
    reset_n = 1'b1;
    chk("rst_ready",  64'(host.req_ready), 64'd1);

    // ADD 1.0 + 2.0 = 3.0
    fpuOut = 16'h4200;
    host.req_valid = 1'b1; host.req_op = FPU_ADD;
    host.req_a = 16'h3C00; host.req_b = 16'h4000; host.req_c = '0;
    tick();
    host.req_valid = 1'b0;
    chk("add_start",  64'(start), 64'd1);
    chk("add_ready",  64'(host.req_ready), 64'd0);
    chk("add_in1",    64'(fpuIn1), 64'h3C00);
    chk("add_in2",    64'(fpuIn2), 64'h4000);
    tick();
    chk("add_start2", 64'(start), 64'd0);
    chk("add_early",  64'(host.resp_valid), 64'd0);
    tick();
    chk("add_valid",  64'(host.resp_valid), 64'd1);
    chk("add_result", 64'(host.resp_result), 64'h4200);
    chk("add_flags",  64'(host.resp_flags), 64'd0);
    chk("add_tmo",    64'(host.resp_timeout), 64'd0);
    tick();
    chk("add_idle",   64'(host.req_ready), 64'd1);

    // DIV by zero raises DZ, sticky follows, then clear
    fpuOut = 16'h7C00; statusFlags = 5'b01000;
    runOp(FPU_DIV, 16'h3C00, 16'h0000, 16'h0, lat);
    chk("div_lat",    64'(lat), 64'd3);
    chk("div_flags",  64'(host.resp_flags), 64'h08);
    chk("div_sticky", 64'(sticky_flags), 64'h08);
    tick();
    statusFlags = '0;
    flags_clear = 1'b1; tick(); flags_clear = 1'b0;
    chk("clr_sticky", 64'(sticky_flags), 64'd0);

    // stub FPU never completes: timeout after 8 WAIT cycles
    fpuDone = 1'b0;
    runOp(FPU_MUL, 16'h4000, 16'h4000, 16'h0, lat);
    chk("tmo_lat",    64'(lat), 64'd10);
    chk("tmo_flag",   64'(host.resp_timeout), 64'd1);
    chk("tmo_result", 64'(host.resp_result), 64'h7E00);
    chk("tmo_flags",  64'(host.resp_flags), 64'h10);
    chk("tmo_sticky", 64'(sticky_flags), 64'h10);
    tick();
    flags_clear = 1'b1; tick(); flags_clear = 1'b0;

    // backpressure: response held, new request blocked until handshake
    fpuDone = 1'b1; fpuOut = 16'h3C00; host.resp_ready = 1'b0;
    runOp(FPU_SUB, 16'h4000, 16'h3C00, 16'h0, lat);
    chk("sub_lat",    64'(lat), 64'd3);
    fpuOut = 16'h4A00;
    host.req_valid = 1'b1; host.req_op = FPU_ADD; host.req_a = 16'h4400; host.req_b = 16'h3C00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid",  64'(host.resp_valid), 64'd1);
      chk("bp_result", 64'(host.resp_result), 64'h3C00);
      chk("bp_ready",  64'(host.req_ready), 64'd0);
    end
    host.resp_ready = 1'b1;
    tick();
    chk("bp_idle",    64'(host.req_ready), 64'd1);
    chk("bp_in1_old", 64'(fpuIn1), 64'h4000);
    tick();
    host.req_valid = 1'b0;
    chk("bp_start",   64'(start), 64'd1);
    chk("bp_in1_new", 64'(fpuIn1), 64'h4400);
    tick(); tick();
    chk("bp2_valid",  64'(host.resp_valid), 64'd1);
    chk("bp2_result", 64'(host.resp_result), 64'h4A00);
    tick();

    // reset during WAIT of MUL abandons the op
    fpuDone = 1'b0; statusFlags = 5'b00001;
    host.req_valid = 1'b1; host.req_op = FPU_MUL; host.req_a = 16'h4200; host.req_b = 16'h4000;
    tick(); host.req_valid = 1'b0;
    tick(); tick();
    chk("mr_busy",    64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_busy0",   64'(busy), 64'd0);
    chk("mr_in1",     64'(fpuIn1), 64'd0);
    chk("mr_op",      64'(op), 64'(FPU_ADD));
    chk("mr_result",  64'(host.resp_result), 64'd0);
    chk("mr_ready",   64'(host.req_ready), 64'd1);
    tick();
    reset_n = 1'b1; fpuDone = 1'b1;
    tick(); tick(); tick();
    chk("mr_novalid", 64'(host.resp_valid), 64'd0);
    chk("mr_sticky",  64'(sticky_flags), 64'd0);
    statusFlags = '0; fpuOut = 16'h4200;
    runOp(FPU_ADD, 16'h3C00, 16'h4000, 16'h0, lat);
    chk("mr_add_lat", 64'(lat), 64'd3);
    chk("mr_add_res", 64'(host.resp_result), 64'h4200);
    tick();

    // flags_clear coincident with capture of an NX op
    fpuOut = 16'h7C00; statusFlags = 5'b01000;
    runOp(FPU_DIV, 16'h3C00, 16'h0000, 16'h0, lat);
    tick();
    chk("cc_pre",     64'(sticky_flags), 64'h08);
    statusFlags = 5'b00001; fpuOut = 16'h3555;
    host.req_valid = 1'b1; host.req_op = FPU_DIV; host.req_a = 16'h3C00; host.req_b = 16'h4200;
    tick(); host.req_valid = 1'b0;
    tick();
    flags_clear = 1'b1;
    tick();
    flags_clear = 1'b0;
    chk("cc_valid",   64'(host.resp_valid), 64'd1);
    chk("cc_flags",   64'(host.resp_flags), 64'h01);
    chk("cc_sticky",  64'(sticky_flags), 64'h01);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
